// File: rtl/epsilon_serializer.sv
// Byte-to-bit serialiser feeding the monobit test: valid/ready byte FIFO,
// LSB-first shifter, and a 16-bit Fibonacci LFSR self-test source.
module epsilon_serializer #(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_dat,
  input  logic        byte_vld,
  output logic        byte_rdy,
  input  logic        mode,
  output logic        epsilon_dat,
  output logic        epsilon_vld,
  output logic        underrun,
  output logic [15:0] bit_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [7:0]  shreg;
  logic [2:0]  idx;
  logic        loaded;
  logic [15:0] lfsr;
  logic        mode_act;

  logic fifo_empty;
  logic push;
  logic boundary;
  logic load;
  logic next_vld;
  logic lfsr_fb;

  assign fifo_empty  = (count == '0);
  assign byte_rdy    = (count < FULL_CNT) && !mode_act;
  assign push        = byte_vld && byte_rdy;
  assign boundary    = !loaded || (idx == 3'd7);
  // Loads use the mode being sampled at this boundary, so a switch to LFSR
  // never pops a byte it would not shift out.
  assign load        = boundary && !fifo_empty && !mode;
  assign next_vld    = !boundary || mode || load;
  assign lfsr_fb     = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  assign epsilon_vld = mode_act || loaded;
  assign epsilon_dat = mode_act ? lfsr[0] : shreg[0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= byte_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      shreg     <= 8'h00;
      idx       <= 3'd0;
      loaded    <= 1'b0;
      lfsr      <= LFSR_SEED;
      mode_act  <= 1'b0;
      underrun  <= 1'b0;
      bit_count <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Shifting in zeros keeps epsilon_dat low once the byte has drained.
      if (load) begin
        shreg  <= mem[rd_ptr];
        idx    <= 3'd0;
        loaded <= 1'b1;
      end else begin
        shreg <= shreg >> 1;
        if (loaded) begin
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
            loaded <= 1'b0;
          end
        end
      end

      if (boundary) begin
        mode_act <= mode;
      end
      if (mode_act) begin
        lfsr <= {lfsr_fb, lfsr[15:1]};
      end

      if (epsilon_vld && !next_vld) begin
        underrun <= 1'b1;
      end
      if (epsilon_vld) begin
        bit_count <= bit_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_epsilon_serializer.sv
// Self-checking bench for epsilon_serializer: expected bits are queued at
// each accepted handshake and popped whenever epsilon_vld is sampled high.
module tb_epsilon_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_dat;
  logic        byte_vld;
  logic        byte_rdy;
  logic        mode;
  logic        epsilon_dat;
  logic        epsilon_vld;
  logic        underrun;
  logic [15:0] bit_count;

  int errors = 0;
  int checks = 0;
  logic exp_q[$];

  epsilon_serializer #(.DEPTH(2), .LFSR_SEED(16'hACE1)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_dat    (byte_dat),
    .byte_vld    (byte_vld),
    .byte_rdy    (byte_rdy),
    .mode        (mode),
    .epsilon_dat (epsilon_dat),
    .epsilon_vld (epsilon_vld),
    .underrun    (underrun),
    .bit_count   (bit_count)
  );

  always #5 clk = ~clk;

  task automatic push_bits(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
  endtask

  task automatic do_reset(input logic m);
    @(posedge clk); #1;
    rst = 1'b1; byte_vld = 1'b0; byte_dat = 8'h00; mode = m;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    @(negedge clk);
    checks++; if (epsilon_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", epsilon_vld); end
    checks++; if (epsilon_dat !== 1'b0) begin errors++; $display("FAIL reset_dat: got %b want 0", epsilon_dat); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    checks++; if (bit_count !== 16'd0) begin errors++; $display("FAIL reset_bit_count: got %0d want 0", bit_count); end
    checks++; if (byte_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", byte_rdy); end
  endtask

  task automatic test_single_byte();
    logic exp_bit;
    logic [7:0] pat;
    pat = 8'hA5;
    do_reset(1'b0);
    byte_dat = pat; byte_vld = 1'b1;
    @(negedge clk);
    if (byte_vld && byte_rdy) push_bits(pat);
    @(posedge clk); #1;
    byte_vld = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 9) begin
        checks++; if (epsilon_vld !== 1'b1) begin errors++; $display("FAIL single_vld c=%0d: got %b want 1", c, epsilon_vld); end
        exp_bit = exp_q.size() > 0 ? exp_q.pop_front() : 1'bx;
        checks++; if (epsilon_dat !== exp_bit) begin errors++; $display("FAIL single_dat c=%0d: got %b want %b", c, epsilon_dat, exp_bit); end
        checks++; if (epsilon_dat !== pat[c-2]) begin errors++; $display("FAIL single_order c=%0d: got %b want %b", c, epsilon_dat, pat[c-2]); end
      end else begin
        checks++; if (epsilon_vld !== 1'b0) begin errors++; $display("FAIL single_idle c=%0d: got %b want 0", c, epsilon_vld); end
      end
      if (c == 9) begin
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL single_underrun_early: got %b want 0", underrun); end
      end
      if (c == 10) begin
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL single_underrun: got %b want 1", underrun); end
        checks++; if (bit_count !== 16'd8) begin errors++; $display("FAIL single_bit_count: got %0d want 8", bit_count); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic exp_bit;
    int bi, first, last, nvld;
    logic und_early, rdy_bad;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h0F;
    bi = 0; first = -1; last = -1; nvld = 0; und_early = 1'b0; rdy_bad = 1'b0;
    do_reset(1'b0);
    byte_vld = 1'b1; byte_dat = bytes[0];
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (epsilon_vld) begin
        if (first < 0) first = c;
        last = c; nvld++;
        if (underrun) und_early = 1'b1;
        exp_bit = exp_q.size() > 0 ? exp_q.pop_front() : 1'bx;
        checks++; if (epsilon_dat !== exp_bit) begin errors++; $display("FAIL b2b_dat c=%0d: got %b want %b", c, epsilon_dat, exp_bit); end
      end
      if (c >= 3 && c <= 9 && byte_rdy !== 1'b0) rdy_bad = 1'b1;
      if (c == 10) begin
        checks++; if (byte_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy_reassert: got %b want 1", byte_rdy); end
      end
      if (byte_vld && byte_rdy) begin push_bits(bytes[bi]); bi++; end
      @(posedge clk); #1;
      byte_vld = (bi < 3);
      byte_dat = (bi < 3) ? bytes[bi] : 8'h00;
    end
    checks++; if (rdy_bad !== 1'b0) begin errors++; $display("FAIL b2b_rdy_full: got %b want 0", rdy_bad); end
    checks++; if (nvld != 24) begin errors++; $display("FAIL b2b_nvld: got %0d want 24", nvld); end
    checks++; if (last - first + 1 != 24) begin errors++; $display("FAIL b2b_gap: got span %0d want 24", last - first + 1); end
    checks++; if (bit_count !== 16'd24) begin errors++; $display("FAIL b2b_bit_count: got %0d want 24", bit_count); end
    checks++; if (und_early !== 1'b0) begin errors++; $display("FAIL b2b_underrun_early: got %b want 0", und_early); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL b2b_underrun_end: got %b want 1", underrun); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_hold_vld();
    logic exp_bit;
    logic [9:0] acc_mask;
    int nacc;
    acc_mask = '0; nacc = 0;
    do_reset(1'b0);
    byte_vld = 1'b1; byte_dat = 8'h10;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (epsilon_vld) begin
        exp_bit = exp_q.size() > 0 ? exp_q.pop_front() : 1'bx;
        checks++; if (epsilon_dat !== exp_bit) begin errors++; $display("FAIL hold_dat c=%0d: got %b want %b", c, epsilon_dat, exp_bit); end
      end
      if (c == 9) begin
        checks++; if (byte_rdy !== 1'b0) begin errors++; $display("FAIL hold_rdy_before_pop: got %b want 0", byte_rdy); end
      end
      if (c == 10) begin
        checks++; if (byte_rdy !== 1'b1) begin errors++; $display("FAIL hold_rdy_after_pop: got %b want 1", byte_rdy); end
      end
      if (byte_vld && byte_rdy) begin
        push_bits(byte_dat);
        nacc++;
        if (c < 10) acc_mask[c] = 1'b1;
      end
      @(posedge clk); #1;
      byte_vld = (c + 1 < 10);
      byte_dat = 8'(8'h10 + c + 1);
    end
    checks++; if (nacc != 3) begin errors++; $display("FAIL hold_accepted: got %0d want 3", nacc); end
    checks++; if (acc_mask !== 10'b0000000111) begin errors++; $display("FAIL hold_accept_cycles: got %b want 0000000111", acc_mask); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL hold_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_lfsr_reset();
    logic [15:0] lfsr_m;
    logic [2:0] first3, want3;
    logic vld_bad, rdy_bad;
    lfsr_m = 16'hACE1; first3 = '0; want3 = 3'b001; vld_bad = 1'b0; rdy_bad = 1'b0;
    do_reset(1'b1);
    @(negedge clk);
    checks++; if (epsilon_vld !== 1'b0) begin errors++; $display("FAIL lfsr_pre_vld: got %b want 0", epsilon_vld); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (epsilon_vld !== 1'b1) vld_bad = 1'b1;
      if (byte_rdy !== 1'b0) rdy_bad = 1'b1;
      if (i < 3) first3[i] = epsilon_dat;
      checks++; if (epsilon_dat !== lfsr_m[0]) begin errors++; $display("FAIL lfsr_dat i=%0d: got %b want %b", i, epsilon_dat, lfsr_m[0]); end
      lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end
    checks++; if (first3 !== want3) begin errors++; $display("FAIL lfsr_first3: got %b want %b", first3, want3); end
    checks++; if (vld_bad !== 1'b0) begin errors++; $display("FAIL lfsr_vld_cont: got %b want 0", vld_bad); end
    checks++; if (rdy_bad !== 1'b0) begin errors++; $display("FAIL lfsr_rdy: got %b want 0", rdy_bad); end
    checks++; if (bit_count !== 16'd19) begin errors++; $display("FAIL lfsr_bit_count: got %0d want 19", bit_count); end
    mode = 1'b0;
  endtask

  task automatic test_mode_switch();
    logic [0:10] pattern;
    pattern = 11'b00111100100;
    do_reset(1'b0);
    byte_dat = 8'h3C; byte_vld = 1'b1;
    @(posedge clk); #1;
    byte_vld = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        checks++; if (epsilon_vld !== 1'b1 || epsilon_dat !== pattern[c-2]) begin
          errors++; $display("FAIL switch_bit c=%0d: got vld=%b dat=%b want vld=1 dat=%b", c, epsilon_vld, epsilon_dat, pattern[c-2]);
        end
      end
      @(posedge clk); #1;
      if (c == 4) mode = 1'b1;
    end
    @(negedge clk);
    checks++; if (byte_rdy !== 1'b0) begin errors++; $display("FAIL switch_rdy: got %b want 0", byte_rdy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL switch_underrun: got %b want 0", underrun); end
    mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic stale;
    stale = 1'b0;
    do_reset(1'b0);
    byte_dat = 8'h96; byte_vld = 1'b1;
    @(posedge clk); #1;
    byte_dat = 8'h5A;
    @(posedge clk); #1;
    byte_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (epsilon_vld !== 1'b1 || epsilon_dat !== 1'b1) begin
      errors++; $display("FAIL midrst_idx4: got vld=%b dat=%b want vld=1 dat=1", epsilon_vld, epsilon_dat);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (epsilon_vld !== 1'b0) begin errors++; $display("FAIL midrst_vld: got %b want 0", epsilon_vld); end
    checks++; if (bit_count !== 16'd0) begin errors++; $display("FAIL midrst_bit_count: got %0d want 0", bit_count); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL midrst_underrun: got %b want 0", underrun); end
    checks++; if (byte_rdy !== 1'b1) begin errors++; $display("FAIL midrst_rdy: got %b want 1", byte_rdy); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (epsilon_vld !== 1'b0 || epsilon_dat !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL midrst_stale: got %b want 0", stale); end
    checks++; if (bit_count !== 16'd0) begin errors++; $display("FAIL midrst_count_after: got %0d want 0", bit_count); end
  endtask

  initial begin
    rst = 1'b1; byte_vld = 1'b0; byte_dat = 8'h00; mode = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_hold_vld();
    test_lfsr_reset();
    test_mode_switch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
